// File: rtl/rx_frame_pkg.sv
// Shared constants, state encoding and status record for the receive frame monitor.
package rx_frame_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [1:0]  SPEED_1000    = 2'b10;
  localparam int          LEN_W         = 11;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DONE, DROP} rx_state_e;

  typedef struct packed {
    logic             good;
    logic             match;
    logic             crc_err;
    logic             len_err;
    logic             rx_err;
    logic             align_err;
    logic [LEN_W-1:0] len;
  } rx_status_t;
endpackage

// File: rtl/rx_frame_monitor_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
module crc32_d8
  import rx_frame_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
  end
endmodule

// File: rtl/rx_frame_monitor.sv
// Receive-side frame checker: delineation, nibble assembly, DA capture, FCS/length
// check, one-cycle status strobe and saturating good/bad counters.
module rx_frame_monitor
  import rx_frame_pkg::*;
#(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  speed,
  input  logic [47:0] mac_address,
  input  logic        mac_valid,
  input  logic [7:0]  rxdat,
  input  logic        rxdv,
  input  logic        rxer,
  output logic        frame_done,
  output logic        frame_good,
  output logic        frame_match,
  output logic [10:0] frame_len,
  output logic        crc_err,
  output logic        len_err,
  output logic        rx_err,
  output logic        align_err,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);
  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DA_BYTES = LEN_W'(6);

  logic [1:0]  speed_q;
  logic [47:0] mac_q;
  logic        mac_vld_q;
  logic [7:0]  rxd_q;
  logic        rxer_q;
  logic [1:0]  vld_pipe;
  logic        rxdv_q, dv_rise;

  rx_state_e   state, state_nxt;
  logic        start, in_pre, in_data, unit_act, eval;

  logic        mode_byte, byte_mode, nib_have;
  logic [3:0]  nib_lo;
  logic        byte_vld, sfd;
  logic [7:0]  byte_val;

  logic [31:0] crc_r, crc_nxt;
  logic [LEN_W-1:0] len_r;
  logic [47:0] da_r;
  logic        rx_err_r, align_r;

  rx_status_t  st_eval, status;
  logic [15:0] good_cnt, bad_cnt;

  // vld_pipe resets high so a frame already running at reset release is never taken as a rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed_q   <= '0;
      mac_q     <= '0;
      mac_vld_q <= 1'b0;
      rxd_q     <= '0;
      rxer_q    <= 1'b0;
      vld_pipe  <= 2'b11;
    end else begin
      speed_q   <= speed;
      mac_q     <= mac_address;
      mac_vld_q <= mac_valid;
      rxd_q     <= rxdat;
      rxer_q    <= rxer;
      vld_pipe  <= {vld_pipe[0], rxdv};
    end
  end

  assign rxdv_q  = vld_pipe[0];
  assign dv_rise = vld_pipe[0] & ~vld_pipe[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The first sample of a frame is consumed on the start cycle, which may also be DONE
  always_comb begin
    start    = dv_rise & ((state == IDLE) | (state == DONE));
    in_pre   = start | (state == PREAMBLE);
    in_data  = (state == DATA);
    unit_act = rxdv_q & (in_pre | in_data);
    eval     = (state == DONE);
  end

  assign byte_mode = start ? (speed_q == SPEED_1000) : mode_byte;
  assign byte_vld  = unit_act & (byte_mode | (nib_have & ~start));
  assign byte_val  = byte_mode ? rxd_q : {rxd_q[3:0], nib_lo};
  assign sfd       = in_pre & byte_vld & (byte_val == SFD_BYTE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? PREAMBLE : IDLE;
      PREAMBLE:   state_nxt = rxdv_q ? PREAMBLE : IDLE;
      DATA:       if (!rxdv_q) state_nxt = DONE;
      DROP:       if (!rxdv_q) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (in_pre & byte_vld)
      state_nxt = (byte_val == PREAMBLE_BYTE) ? PREAMBLE :
                  (byte_val == SFD_BYTE)      ? DATA     : DROP;
  end

  crc32_d8 u_crc (.crc(crc_r), .data(byte_val), .crc_next(crc_nxt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_byte <= 1'b0;
      nib_have  <= 1'b0;
      nib_lo    <= '0;
      crc_r     <= CRC_INIT;
      len_r     <= '0;
      da_r      <= '0;
      rx_err_r  <= 1'b0;
      align_r   <= 1'b0;
    end else begin
      if (start) mode_byte <= (speed_q == SPEED_1000);
      if (unit_act & ~byte_mode) begin
        nib_lo   <= rxd_q[3:0];
        nib_have <= ~(nib_have & ~start);
      end else begin
        nib_have <= 1'b0;
      end
      if (sfd) begin
        crc_r    <= CRC_INIT;
        len_r    <= '0;
        da_r     <= '0;
        rx_err_r <= 1'b0;
        align_r  <= 1'b0;
      end else if (in_data) begin
        if (rxdv_q) begin
          if (rxer_q) rx_err_r <= 1'b1;
          if (byte_vld) begin
            crc_r <= crc_nxt;
            if (len_r != '1)      len_r <= len_r + 1'b1;
            if (len_r < DA_BYTES) da_r  <= {da_r[39:0], byte_val};
          end
        end else begin
          align_r <= nib_have;
        end
      end
    end
  end

  always_comb begin
    st_eval           = '0;
    st_eval.len       = len_r;
    st_eval.crc_err   = (crc_r != CRC_RESIDUE);
    st_eval.len_err   = (len_r < MIN_L) || (len_r > MAX_L);
    st_eval.rx_err    = rx_err_r;
    st_eval.align_err = align_r;
    st_eval.match     = (len_r >= DA_BYTES) && ((mac_vld_q && (da_r == mac_q)) || (&da_r));
    st_eval.good      = !(st_eval.crc_err || st_eval.len_err || rx_err_r || align_r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done <= 1'b0;
      status     <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      frame_done <= eval;
      if (eval) begin
        status <= st_eval;
        if (st_eval.good) begin
          if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
        end else begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end
      end
    end
  end

  assign frame_good  = status.good;
  assign frame_match = status.match;
  assign frame_len   = status.len;
  assign crc_err     = status.crc_err;
  assign len_err     = status.len_err;
  assign rx_err      = status.rx_err;
  assign align_err   = status.align_err;
  assign good_count  = good_cnt;
  assign bad_count   = bad_cnt;
endmodule

// File: tb/tb_rx_frame_monitor.sv
// Randomized bench for rx_frame_monitor against a frame-level reference model.
module tb_rx_frame_monitor;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  speed;
  logic [47:0] mac_address;
  logic        mac_valid;
  logic [7:0]  rxdat;
  logic        rxdv, rxer;
  logic        frame_done, frame_good, frame_match;
  logic [10:0] frame_len;
  logic        crc_err, len_err, rx_err, align_err;
  logic [15:0] good_count, bad_count;

  rx_frame_monitor dut (
    .clk(clk), .rst(rst), .speed(speed), .mac_address(mac_address), .mac_valid(mac_valid),
    .rxdat(rxdat), .rxdv(rxdv), .rxer(rxer), .frame_done(frame_done), .frame_good(frame_good),
    .frame_match(frame_match), .frame_len(frame_len), .crc_err(crc_err), .len_err(len_err),
    .rx_err(rx_err), .align_err(align_err), .good_count(good_count), .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  wire [49:0] outs = {frame_done, frame_good, frame_match, frame_len, crc_err, len_err,
                      rx_err, align_err, good_count, bad_count};

  typedef struct {
    logic good, match, crc_e, len_e, rx_e, al_e;
    int   len, gc, bc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fr[$];
  int         errs = 0, checks = 0, strobes = 0;
  int         m_good = 0, m_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-serial FCS over the first n bytes, transmitted complement
  function automatic logic [31:0] fcs_of(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ q[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  task automatic build(input int n, input int kind, input bit bad);
    logic [31:0] f;
    logic [47:0] da;
    fr.delete();
    da = (kind == 0) ? mac_address : (kind == 1) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), $urandom};
    for (int i = 0; i < n - 4; i++) fr.push_back(i < 6 ? da[47-8*i -: 8] : 8'($urandom));
    f = fcs_of(fr, n - 4);
    for (int k = 0; k < 4; k++) fr.push_back(f[8*k +: 8]);
    if (bad) fr[n-1] = fr[n-1] ^ 8'h80;
  endtask

  task automatic unit(input logic [7:0] d, input logic dv, input logic er);
    @(posedge clk); #1;
    rxdat = d; rxdv = dv; rxer = er;
  endtask

  task automatic put_byte(input logic [7:0] b, input bit nib, input logic er);
    if (!nib) unit(b, 1'b1, er);
    else begin
      unit({4'($urandom), b[3:0]}, 1'b1, er);
      unit({4'($urandom), b[7:4]}, 1'b1, 1'b0);
    end
  endtask

  task automatic send(input bit nib, input int rxer_idx, input bit extra, input bit timing, input bit gap1);
    exp_t e;
    int n;
    logic [47:0] da;
    n  = fr.size();
    da = '0;
    for (int i = 0; i < 6 && i < n; i++) da = {da[39:0], fr[i]};
    e.crc_e = ({fr[n-1], fr[n-2], fr[n-3], fr[n-4]} != fcs_of(fr, n - 4));
    e.len_e = (n < 64) || (n > 1522);
    e.rx_e  = (rxer_idx >= 0) && (rxer_idx < n);
    e.al_e  = extra;
    e.match = (n >= 6) && ((da == 48'hFFFF_FFFF_FFFF) || (mac_valid && da == mac_address));
    e.good  = !(e.crc_e || e.len_e || e.rx_e || e.al_e);
    e.len   = (n > 2047) ? 2047 : n;
    if (e.good) m_good = (m_good < 65535) ? m_good + 1 : m_good;
    else        m_bad  = (m_bad  < 65535) ? m_bad  + 1 : m_bad;
    e.gc = m_good;
    e.bc = m_bad;
    sb.push_back(e);
    speed = nib ? 2'($urandom_range(0, 1)) : 2'b10;
    for (int i = 0; i < 8; i++) put_byte(i < 7 ? 8'h55 : 8'hD5, nib, 1'($urandom));
    for (int j = 0; j < n; j++) put_byte(fr[j], nib, j == rxer_idx);
    if (extra) unit(8'($urandom), 1'b1, 1'b0);
    unit(8'($urandom), 1'b0, 1'($urandom));
    if (timing) begin
      @(posedge clk); @(posedge clk); #1 chk("done_early", frame_done, 0);
      @(posedge clk); #1 chk("done_edge", frame_done, 1);
      @(posedge clk); #1 chk("done_pulse", frame_done, 0);
    end else if (!gap1) repeat (4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_done) begin
      strobes++;
      if (sb.size() == 0) chk("spurious_strobe", 1, 0);
      else begin
        e = sb.pop_front();
        chk("status", {frame_good, frame_match, crc_err, len_err, rx_err, align_err},
                      {e.good, e.match, e.crc_e, e.len_e, e.rx_e, e.al_e});
        chk("frame_len", frame_len, e.len);
        chk("counts", {good_count, bad_count}, {e.gc[15:0], e.bc[15:0]});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bit prev_gap;
    rst = 1'b0; rxdv = 1'b0; rxer = 1'b0; rxdat = 8'h00; speed = 2'b10;
    mac_address = 48'h02_11_22_33_44_55; mac_valid = 1'b1;
    #23 chk("reset_out", outs, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    build(64, 0, 0); send(0, -1, 0, 1, 0);
    mac_valid = 1'b0;
    build(64, 1, 0); send(1, -1, 0, 1, 0);
    build(64, 0, 0); send(1, -1, 0, 0, 0);
    mac_valid = 1'b1;
    build(64, 0, 1); send(0, -1, 0, 0, 0);
    build(80, 0, 0); send(0, 20, 0, 0, 0);
    build(63, 0, 0);   send(0, -1, 0, 0, 0);
    build(1523, 1, 0); send(0, -1, 0, 0, 0);
    build(1522, 0, 0); send(0, -1, 0, 0, 0);
    build(2100, 0, 0); send(0, -1, 0, 0, 0);
    build(70, 0, 0);   send(1, -1, 1, 0, 0);
    build(5, 1, 0);    send(0, -1, 0, 0, 0);

    s0 = strobes;
    speed = 2'b10;
    unit(8'h55, 1, 0); unit(8'h55, 1, 0); unit(8'hAB, 1, 0);
    for (int i = 0; i < 10; i++) unit(i == 4 ? 8'hD5 : 8'($urandom), 1, 1'($urandom));
    unit(8'h00, 0, 0);
    repeat (6) @(posedge clk);
    chk("drop_no_strobe", strobes, s0);

    build(64, 0, 0); send(0, -1, 0, 0, 1);
    build(66, 1, 0); send(1, -1, 0, 0, 1);
    build(64, 0, 0); send(0, -1, 0, 1, 0);

    s0 = strobes;
    build(100, 0, 0);
    speed = 2'b10;
    for (int i = 0; i < 8; i++) put_byte(i < 7 ? 8'h55 : 8'hD5, 0, 0);
    for (int j = 0; j < 30; j++) put_byte(fr[j], 0, 0);
    #2 rst = 1'b0;
    #1 chk("rst_mid_out", outs, 0);
    m_good = 0; m_bad = 0;
    @(negedge clk); rst = 1'b1;
    for (int j = 30; j < 100; j++) put_byte(fr[j], 0, 0);
    unit(8'h00, 0, 0);
    repeat (6) @(posedge clk);
    chk("rst_no_strobe", strobes, s0);
    build(64, 0, 0); send(0, -1, 0, 0, 0);

    prev_gap = 0;
    for (int k = 0; k < 30; k++) begin
      int n, rx_i;
      bit nib, g1;
      if (!prev_gap) mac_valid = 1'($urandom);
      n    = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 80) : $urandom_range(60, 200);
      nib  = 1'($urandom);
      rx_i = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      g1   = 1'($urandom);
      build(n, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      send(nib, rx_i, nib && ($urandom_range(0, 4) == 0), 0, g1);
      prev_gap = g1;
    end
    repeat (6) @(posedge clk);

    @(negedge clk); force dut.good_cnt = 16'hFFFE;
    @(negedge clk); release dut.good_cnt;
    m_good = 65534;
    mac_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin build(64, 0, 0); send(0, -1, 0, 0, 0); end
    chk("sat_hold", good_count, 16'hFFFF);

    repeat (10) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
